// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared opcodes, ALU codes and control bundle layout
package pipe_ctrl_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // ALU operation codes; the narrow ALU only implements 0..3 and slt
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  // Write-back result select
  localparam logic [1:0] RESULT_ALU = 2'd0;
  localparam logic [1:0] RESULT_MEM = 2'd1;
  localparam logic [1:0] RESULT_PC4 = 2'd2;

  // Full bundle produced in D and held in the ID/EX register
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       alu_a_pc;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] funct3;
  } ctrl_t;

  // Subset carried into M
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } mem_ctrl_t;

  // Subset carried into W
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } wb_ctrl_t;

  // Arithmetic/logic op for R-type and I-ALU; only R-type can select sub
  function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic f7b5,
                                           input logic is_r);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  // Whether an ALU code is implemented by an ALU of the given control width
  function automatic logic alu_code_ok(input logic [3:0] code, input int aluc_w);
    return (aluc_w >= 4) || (code <= ALU_OR) || (code == ALU_SLT);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational D-stage decode of op/funct3/funct7b5
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUC_W      = 3,
  parameter int IMMS_W      = 2,
  parameter int BRANCH_FULL = 1
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output ctrl_t      ctrl,
  output logic [2:0] imm_src,
  output logic       illegal
);

  ctrl_t      raw;
  logic [2:0] raw_imm;
  logic       bad;

  // Decode the opcode, then zero the whole bundle if anything is unsupported
  always_comb begin
    raw        = '0;
    raw.funct3 = funct3;
    raw_imm    = IMM_I;
    bad        = 1'b0;
    case (op)
      OP_LOAD: begin
        raw.reg_write  = 1'b1;
        raw.result_src = RESULT_MEM;
        raw.alu_src    = 1'b1;
        raw.alu_ctrl   = ALU_ADD;
      end
      OP_STORE: begin
        raw.mem_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.alu_ctrl  = ALU_ADD;
        raw_imm       = IMM_S;
      end
      OP_R: begin
        raw.reg_write = 1'b1;
        raw.alu_ctrl  = alu_arith(funct3, funct7b5, 1'b1);
      end
      OP_I: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.alu_ctrl  = alu_arith(funct3, funct7b5, 1'b0);
      end
      OP_BR: begin
        raw.branch   = 1'b1;
        raw.alu_ctrl = ALU_SUB;
        raw_imm      = IMM_B;
        if (funct3[2:1] == 2'b01) bad = 1'b1;
        if ((BRANCH_FULL == 0) && funct3[2]) bad = 1'b1;
      end
      OP_JAL: begin
        raw.reg_write  = 1'b1;
        raw.jump       = 1'b1;
        raw.result_src = RESULT_PC4;
        raw_imm        = IMM_J;
      end
      OP_JALR: begin
        raw.reg_write  = 1'b1;
        raw.jump       = 1'b1;
        raw.jalr       = 1'b1;
        raw.alu_src    = 1'b1;
        raw.alu_ctrl   = ALU_ADD;
        raw.result_src = RESULT_PC4;
      end
      OP_LUI: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.alu_ctrl  = ALU_PASSB;
        raw_imm       = IMM_U;
        if (IMMS_W < 3) bad = 1'b1;
      end
      OP_AUIPC: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = 1'b1;
        raw.alu_a_pc  = 1'b1;
        raw.alu_ctrl  = ALU_ADD;
        raw_imm       = IMM_U;
        if (IMMS_W < 3) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (!alu_code_ok(raw.alu_ctrl, ALUC_W)) bad = 1'b1;
  end

  assign illegal = bad;
  assign ctrl    = bad ? '0 : raw;
  assign imm_src = bad ? IMM_I : raw_imm;

endmodule

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - pipelined RV32I control: decode, E/M/W registers, branch resolve
module pipe_control
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUC_W      = 3,
  parameter int IMMS_W      = 2,
  parameter int BRANCH_FULL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        op_d,
  input  logic [2:0]        funct3_d,
  input  logic              funct7b5_d,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              zero_e,
  input  logic              lt_e,
  input  logic              ltu_e,
  output logic [IMMS_W-1:0] imm_src_d,
  output logic              illegal_d,
  output logic [ALUC_W-1:0] alu_ctrl_e,
  output logic              alu_src_e,
  output logic              alu_a_pc_e,
  output logic              jalr_e,
  output logic              pc_src_e,
  output logic [1:0]        result_src_e,
  output logic              reg_write_m,
  output logic              mem_write_m,
  output logic [1:0]        result_src_m,
  output logic              reg_write_w,
  output logic [1:0]        result_src_w
);

  ctrl_t      dec_ctrl;
  logic [2:0] dec_imm;
  ctrl_t      ex_d, ex_q;
  mem_ctrl_t  mem_d, mem_q;
  wb_ctrl_t   wb_d, wb_q;
  logic       cond_e;

  ctrl_decode #(
    .ALUC_W      (ALUC_W),
    .IMMS_W      (IMMS_W),
    .BRANCH_FULL (BRANCH_FULL)
  ) u_decode (
    .op       (op_d),
    .funct3   (funct3_d),
    .funct7b5 (funct7b5_d),
    .ctrl     (dec_ctrl),
    .imm_src  (dec_imm),
    .illegal  (illegal_d)
  );

  assign imm_src_d = dec_imm[IMMS_W-1:0];

  // ID/EX next value: a flush bubble wins over a stall hold
  always_comb begin
    ex_d = dec_ctrl;
    if (flush_e) begin
      ex_d = '0;
    end else if (stall_e) begin
      ex_d = ex_q;
    end
  end

  // EX/MEM and MEM/WB simply take the previous stage every cycle
  always_comb begin
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.result_src = ex_q.result_src;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.result_src  = mem_q.result_src;
  end

  // Stage registers, all cleared together by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Branch condition selected by the funct3 carried into E
  always_comb begin
    case (ex_q.funct3)
      3'b000:  cond_e = zero_e;
      3'b001:  cond_e = !zero_e;
      3'b100:  cond_e = lt_e;
      3'b101:  cond_e = !lt_e;
      3'b110:  cond_e = ltu_e;
      3'b111:  cond_e = !ltu_e;
      default: cond_e = 1'b0;
    endcase
  end

  assign pc_src_e     = ex_q.jump | (ex_q.branch & cond_e);
  assign alu_ctrl_e   = ex_q.alu_ctrl[ALUC_W-1:0];
  assign alu_src_e    = ex_q.alu_src;
  assign alu_a_pc_e   = ex_q.alu_a_pc;
  assign jalr_e       = ex_q.jalr;
  assign result_src_e = ex_q.result_src;
  assign reg_write_m  = mem_q.reg_write;
  assign mem_write_m  = mem_q.mem_write;
  assign result_src_m = mem_q.result_src;
  assign reg_write_w  = wb_q.reg_write;
  assign result_src_w = wb_q.result_src;

endmodule
